// File: rtl/rv_ctrl_pkg.sv
// Shared constants for the sequencing controller and the instruction decoder:
// RV64 major opcodes, controller FSM encoding and trap cause codes.
package rv_ctrl_pkg;

    localparam logic [6:0] OpcLoad    = 7'b0000011;
    localparam logic [6:0] OpcMiscMem = 7'b0001111;
    localparam logic [6:0] OpcOpImm   = 7'b0010011;
    localparam logic [6:0] OpcAuipc   = 7'b0010111;
    localparam logic [6:0] OpcOpImm32 = 7'b0011011;
    localparam logic [6:0] OpcStore   = 7'b0100011;
    localparam logic [6:0] OpcOp      = 7'b0110011;
    localparam logic [6:0] OpcLui     = 7'b0110111;
    localparam logic [6:0] OpcOp32    = 7'b0111011;
    localparam logic [6:0] OpcBranch  = 7'b1100011;
    localparam logic [6:0] OpcJalr    = 7'b1100111;
    localparam logic [6:0] OpcJal     = 7'b1101111;
    localparam logic [6:0] OpcSystem  = 7'b1110011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4,
        StTrap   = 3'd5
    } ctrl_state_e;

    typedef enum logic [1:0] {
        CauseNone       = 2'd0,
        CauseIllegal    = 2'd1,
        CauseLsuTimeout = 2'd2
    } trap_cause_e;

endpackage

// File: rtl/seq_ctrl_if.sv
// Fetch and load/store handshake bundle between the sequencing controller
// (master) and the fetch unit / LSU (slave).
interface seq_ctrl_if;

    logic        ifu_req_valid;
    logic        ifu_rsp_valid;
    logic [31:0] inst_in;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic        lsu_store;
    logic        lsu_rsp_valid;

    modport master (
        output ifu_req_valid,
        input  ifu_rsp_valid,
        input  inst_in,
        output lsu_req_valid,
        input  lsu_req_ready,
        output lsu_store,
        input  lsu_rsp_valid
    );

    modport slave (
        input  ifu_req_valid,
        output ifu_rsp_valid,
        output inst_in,
        input  lsu_req_valid,
        output lsu_req_ready,
        input  lsu_store,
        output lsu_rsp_valid
    );

endinterface

// File: rtl/opcode_class.sv
// Opcode legality and class lookup: which major opcodes are implemented,
// which touch data memory, and which produce a register result.
module opcode_class
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic       legal,
    output logic       is_mem,
    output logic       is_store,
    output logic       writes_rd
);

    always_comb begin
        legal     = 1'b1;
        is_mem    = 1'b0;
        is_store  = 1'b0;
        writes_rd = 1'b1;
        unique case (opcode)
            OpcLoad: begin
                is_mem = 1'b1;
            end
            OpcStore: begin
                is_mem    = 1'b1;
                is_store  = 1'b1;
                writes_rd = 1'b0;
            end
            OpcMiscMem, OpcBranch, OpcSystem: begin
                writes_rd = 1'b0;
            end
            OpcOpImm, OpcAuipc, OpcOpImm32, OpcOp, OpcLui, OpcOp32, OpcJalr, OpcJal: begin
                writes_rd = 1'b1;
            end
            default: begin
                legal     = 1'b0;
                writes_rd = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, optional memory
// access with timeout, write-back/retire, and a sticky terminal trap state.
module seq_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    seq_ctrl_if.master      bus,
    output logic [31:0]     inst_q,
    input  logic [6:0]      opcode,
    input  logic [4:0]      rd,
    output logic            rf_we,
    output logic            pc_we,
    output logic            retire,
    output logic [XLEN-1:0] instret,
    output logic            trap,
    output logic [1:0]      trap_cause
);

    localparam logic [7:0] MemLimit = 8'(MEM_TIMEOUT - 1);

    ctrl_state_e     state_q, state_d;
    trap_cause_e     cause_q, cause_d;
    logic [31:0]     inst_d;
    logic [XLEN-1:0] instret_q, instret_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            trap_q, trap_d;

    logic legal, is_mem, is_store, writes_rd;
    logic accept, rsp_ok;

    opcode_class u_opcode_class (
        .opcode    (opcode),
        .legal     (legal),
        .is_mem    (is_mem),
        .is_store  (is_store),
        .writes_rd (writes_rd)
    );

    // A response only counts once the request has been accepted (this cycle or earlier).
    assign accept = (state_q == StMem) && !acc_q && bus.lsu_req_ready;
    assign rsp_ok = (state_q == StMem) && (acc_q || bus.lsu_req_ready) && bus.lsu_rsp_valid;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        trap_d    = trap_q;
        unique case (state_q)
            StFetch: begin
                if (bus.ifu_rsp_valid) begin
                    inst_d  = bus.inst_in;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (legal) begin
                    state_d = StExec;
                end else begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseIllegal;
                end
            end
            StExec: begin
                cnt_d   = 8'd0;
                acc_d   = 1'b0;
                state_d = is_mem ? StMem : StWb;
            end
            StMem: begin
                cnt_d = cnt_q + 8'd1;
                if (accept) begin
                    acc_d = 1'b1;
                end
                if (rsp_ok) begin
                    state_d = StWb;
                end else if (cnt_q == MemLimit) begin
                    state_d = StTrap;
                    trap_d  = 1'b1;
                    cause_d = CauseLsuTimeout;
                end
            end
            StWb: begin
                instret_d = instret_q + XLEN'(1);
                state_d   = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StFetch;
            cause_q   <= CauseNone;
            inst_q    <= 32'd0;
            instret_q <= '0;
            cnt_q     <= 8'd0;
            acc_q     <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            inst_q    <= inst_d;
            instret_q <= instret_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            trap_q    <= trap_d;
        end
    end

    // Reset state is FETCH, so the fetch request is gated by rst to stay quiet while held.
    always_comb begin
        bus.ifu_req_valid = rst && (state_q == StFetch);
        bus.lsu_req_valid = (state_q == StMem) && !acc_q;
        bus.lsu_store     = (state_q == StMem) && !acc_q && is_store;
        pc_we             = (state_q == StWb);
        retire            = (state_q == StWb);
        rf_we             = (state_q == StWb) && writes_rd && (rd != 5'd0);
    end

    assign instret    = instret_q;
    assign trap       = trap_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed scenarios plus randomized
// instruction streams compared against an instruction-level reference model.
module tb_seq_ctrl;

    localparam int unsigned XLEN        = 64;
    localparam int unsigned MEM_TIMEOUT = 16;

    localparam logic [6:0] LegalOps [13] = '{
        7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33,
        7'h37, 7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73
    };

    logic            clk;
    logic            rst;
    logic [31:0]     inst_q;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic            rf_we, pc_we, retire, trap;
    logic [XLEN-1:0] instret;
    logic [1:0]      trap_cause;

    int              checks;
    int              failures;
    logic [XLEN-1:0] exp_instret;

    seq_ctrl_if bus ();

    seq_ctrl #(
        .XLEN        (XLEN),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .inst_q     (inst_q),
        .opcode     (opcode),
        .rd         (rd),
        .rf_we      (rf_we),
        .pc_we      (pc_we),
        .retire     (retire),
        .instret    (instret),
        .trap       (trap),
        .trap_cause (trap_cause)
    );

    // Stand-in decoder: fields of the latched instruction word.
    assign opcode = inst_q[6:0];
    assign rd     = inst_q[11:7];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit is_mem_op(input logic [6:0] op);
        return (op == 7'h03) || (op == 7'h23);
    endfunction

    function automatic bit exp_rf_we(input logic [31:0] w);
        bit no_rd;
        no_rd = (w[6:0] == 7'h23) || (w[6:0] == 7'h63) || (w[6:0] == 7'h0f) || (w[6:0] == 7'h73);
        return !no_rd && (w[11:7] != 5'd0);
    endfunction

    function automatic int exp_latency(input logic [31:0] w, input int rdy, input int rsp);
        if (is_mem_op(w[6:0])) return 4 + rdy + rsp;
        return 3;
    endfunction

    task automatic clear_inputs();
        bus.ifu_rsp_valid = 1'b0;
        bus.inst_in       = 32'd0;
        bus.lsu_req_ready = 1'b0;
        bus.lsu_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_instret = '0;
    endtask

    // Drives one instruction; cycle c=0 is the fetch-response cycle. rsp < 0 means no response.
    task automatic drive_instr(input logic [31:0] word, input int fwait, input int rdy,
                               input int rsp, input bit early, output int lat, output int n_acc,
                               output logic st_acc, output logic rfwe_ret, output logic trap_seen,
                               output int req_low);
        int c;
        int m;
        bit done;
        lat = -1; n_acc = 0; st_acc = 1'b0; rfwe_ret = 1'b0; trap_seen = 1'b0; req_low = 0;
        for (int i = 0; i < fwait; i++) begin
            bus.ifu_rsp_valid = 1'b0;
            #1;
            if (bus.ifu_req_valid !== 1'b1) req_low++;
            @(posedge clk); #1;
        end
        done = 1'b0;
        c = 0;
        while (!done && c < 60) begin
            m = c - 3;
            bus.ifu_rsp_valid = (c == 0) || (c == 2);
            bus.inst_in       = (c == 0) ? word : ~word;
            bus.lsu_req_ready = (m >= rdy);
            bus.lsu_rsp_valid = (rsp >= 0 && m == rdy + rsp) || (early && rdy > 0 && m == rdy - 1);
            #1;
            if (c == 0 && bus.ifu_req_valid !== 1'b1) req_low++;
            if (bus.lsu_req_valid && bus.lsu_req_ready) begin
                n_acc++;
                st_acc = bus.lsu_store;
            end
            if (retire) begin
                lat = c; rfwe_ret = rf_we; done = 1'b1;
            end else if (trap) begin
                lat = c; trap_seen = 1'b1; done = 1'b1;
            end
            @(posedge clk); #1;
            c++;
        end
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #2 rst = 1'b0;
        #3;
        checks++;
        if ({bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_store, rf_we, pc_we, retire} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_store, rf_we, pc_we, retire});
        end
        checks++;
        if ({inst_q, instret, trap, trap_cause} !== '0) begin
            failures++;
            $display("FAIL reset_state: inst_q=%h instret=%0d trap=%b cause=%0d want all 0",
                     inst_q, instret, trap, trap_cause);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_instret = '0;
        #1;
        checks++;
        if (bus.ifu_req_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ifu_req: got %b want 1", bus.ifu_req_valid);
        end
    endtask

    task automatic test_addi();
        int lat, n_acc, req_low;
        logic st, rfwe, tr;
        drive_instr(32'h0010_0093, 0, 0, 0, 1'b0, lat, n_acc, st, rfwe, tr, req_low);
        exp_instret++;
        checks++;
        if (lat !== 3) begin
            failures++; $display("FAIL addi_latency: got %0d want 3", lat);
        end
        checks++;
        if (rfwe !== 1'b1) begin
            failures++; $display("FAIL addi_rf_we: got %b want 1", rfwe);
        end
        checks++;
        if (instret !== exp_instret) begin
            failures++; $display("FAIL addi_instret: got %0d want %0d", instret, exp_instret);
        end
    endtask

    task automatic test_lw();
        int lat, n_acc, req_low;
        logic st, rfwe, tr;
        drive_instr(32'h0002_a283, 1, 2, 3, 1'b1, lat, n_acc, st, rfwe, tr, req_low);
        exp_instret++;
        checks++;
        if (lat !== 9) begin
            failures++; $display("FAIL lw_latency: got %0d want 9", lat);
        end
        checks++;
        if (n_acc !== 1 || st !== 1'b0) begin
            failures++; $display("FAIL lw_accept: accepts=%0d store=%b want 1 and 0", n_acc, st);
        end
        checks++;
        if (rfwe !== 1'b1 || instret !== exp_instret) begin
            failures++;
            $display("FAIL lw_wb: rf_we=%b instret=%0d want 1 and %0d", rfwe, instret, exp_instret);
        end
    endtask

    task automatic test_sw();
        int lat, n_acc, req_low;
        logic st, rfwe, tr;
        drive_instr(32'h0062_a023, 0, 1, 0, 1'b0, lat, n_acc, st, rfwe, tr, req_low);
        exp_instret++;
        checks++;
        if (lat !== 5) begin
            failures++; $display("FAIL sw_latency: got %0d want 5", lat);
        end
        checks++;
        if (n_acc !== 1 || st !== 1'b1) begin
            failures++; $display("FAIL sw_accept: accepts=%0d store=%b want 1 and 1", n_acc, st);
        end
        checks++;
        if (rfwe !== 1'b0 || instret !== exp_instret) begin
            failures++;
            $display("FAIL sw_wb: rf_we=%b instret=%0d want 0 and %0d", rfwe, instret, exp_instret);
        end
    endtask

    task automatic test_random();
        int lat, n_acc, req_low, fwait, rdy, rsp;
        logic st, rfwe, tr;
        logic [31:0] r, word;
        bit early;
        for (int n = 0; n < 40; n++) begin
            r     = $urandom();
            word  = {r[31:12], 5'($urandom_range(0, 31)), LegalOps[$urandom_range(0, 12)]};
            fwait = $urandom_range(0, 3);
            rdy   = $urandom_range(0, 4);
            rsp   = $urandom_range(0, 4);
            early = 1'($urandom_range(0, 1));
            drive_instr(word, fwait, rdy, rsp, early, lat, n_acc, st, rfwe, tr, req_low);
            exp_instret++;
            checks++;
            if (lat !== exp_latency(word, rdy, rsp) || tr !== 1'b0) begin
                failures++;
                $display("FAIL rand_latency[%0d] word=%h: got %0d trap=%b want %0d", n, word, lat,
                         tr, exp_latency(word, rdy, rsp));
            end
            checks++;
            if (n_acc !== (is_mem_op(word[6:0]) ? 1 : 0) ||
                (is_mem_op(word[6:0]) && st !== (word[6:0] == 7'h23))) begin
                failures++;
                $display("FAIL rand_lsu[%0d] word=%h: accepts=%0d store=%b", n, word, n_acc, st);
            end
            checks++;
            if (rfwe !== exp_rf_we(word)) begin
                failures++;
                $display("FAIL rand_rf_we[%0d] word=%h: got %b want %b", n, word, rfwe,
                         exp_rf_we(word));
            end
            checks++;
            if (instret !== exp_instret || inst_q !== word || req_low !== 0) begin
                failures++;
                $display("FAIL rand_state[%0d]: instret=%0d inst_q=%h req_low=%0d want %0d %h 0",
                         n, instret, inst_q, req_low, exp_instret, word);
            end
        end
    endtask

    task automatic test_illegal();
        int lat, n_acc, req_low, bad;
        logic st, rfwe, tr;
        drive_instr(32'h0000_0557, 0, 0, -1, 1'b0, lat, n_acc, st, rfwe, tr, req_low);
        checks++;
        if (tr !== 1'b1 || lat !== 2 || trap_cause !== 2'd1) begin
            failures++;
            $display("FAIL illegal_trap: trap=%b at=%0d cause=%0d want 1 2 1", tr, lat, trap_cause);
        end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus.ifu_rsp_valid = 1'b1;
            bus.inst_in       = 32'h0010_0093;
            #1;
            if (bus.ifu_req_valid || bus.lsu_req_valid || retire || pc_we || rf_we || !trap ||
                trap_cause !== 2'd1) bad++;
            @(posedge clk); #1;
        end
        clear_inputs();
        checks++;
        if (bad !== 0 || instret !== exp_instret || inst_q !== 32'h0000_0557) begin
            failures++;
            $display("FAIL illegal_hold: bad_cycles=%0d instret=%0d inst_q=%h want 0 %0d 00000557",
                     bad, instret, inst_q, exp_instret);
        end
    endtask

    task automatic test_timeout();
        int lat, n_acc, req_low;
        logic st, rfwe, tr;
        do_reset();
        drive_instr(32'h0000_2103, 0, 0, -1, 1'b0, lat, n_acc, st, rfwe, tr, req_low);
        checks++;
        if (tr !== 1'b1 || trap_cause !== 2'd2) begin
            failures++;
            $display("FAIL timeout_cause: trap=%b cause=%0d want 1 2", tr, trap_cause);
        end
        checks++;
        if (lat < 3 + int'(MEM_TIMEOUT) || lat > 4 + int'(MEM_TIMEOUT) || n_acc !== 1) begin
            failures++;
            $display("FAIL timeout_timing: trap at cycle %0d accepts=%0d want %0d..%0d and 1",
                     lat, n_acc, 3 + MEM_TIMEOUT, 4 + MEM_TIMEOUT);
        end
        checks++;
        if (bus.lsu_req_valid !== 1'b0 || instret !== exp_instret) begin
            failures++;
            $display("FAIL timeout_outputs: lsu_req=%b instret=%0d want 0 %0d", bus.lsu_req_valid,
                     instret, exp_instret);
        end
    endtask

    task automatic test_reset_mid();
        int lat, n_acc, req_low;
        logic st, rfwe, tr;
        do_reset();
        drive_instr(32'h0010_0093, 0, 0, 0, 1'b0, lat, n_acc, st, rfwe, tr, req_low);
        bus.ifu_rsp_valid = 1'b1;
        bus.inst_in       = 32'h0000_2103;
        @(posedge clk); #1;
        bus.ifu_rsp_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (bus.lsu_req_valid !== 1'b1) begin
            failures++; $display("FAIL midmem_reached: lsu_req=%b want 1", bus.lsu_req_valid);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus.ifu_req_valid, bus.lsu_req_valid, bus.lsu_store, rf_we, pc_we, retire, trap,
             trap_cause} !== 9'b0 || inst_q !== 32'd0 || instret !== '0) begin
            failures++;
            $display("FAIL midmem_reset: ifu=%b lsu=%b inst_q=%h instret=%0d trap=%b want 0",
                     bus.ifu_req_valid, bus.lsu_req_valid, inst_q, instret, trap);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_instret = '0;
        #1;
        checks++;
        if (bus.ifu_req_valid !== 1'b1) begin
            failures++; $display("FAIL midmem_release: ifu_req=%b want 1", bus.ifu_req_valid);
        end
        @(posedge clk); #1;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (bus.ifu_req_valid !== 1'b0) begin
            failures++; $display("FAIL midfetch_reset: ifu_req=%b want 0", bus.ifu_req_valid);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        drive_instr(32'h0050_0313, 0, 0, 0, 1'b0, lat, n_acc, st, rfwe, tr, req_low);
        exp_instret++;
        checks++;
        if (lat !== 3 || instret !== exp_instret || rfwe !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_addi: lat=%0d instret=%0d rf_we=%b want 3 %0d 1", lat,
                     instret, exp_instret, rfwe);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_instret = '0;
        test_reset();
        test_addi();
        test_lw();
        test_sw();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 64: width of instret counter.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 16: max cycles in MEM before trap, legal range 2..255.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ifu_req_valid  output  1  instruction fetch request.
REQ-006 SHALL have port ifu_rsp_valid  input  1  fetched word valid on inst_in.
REQ-007 SHALL have port inst_in  input  32  fetched instruction word.
REQ-008 SHALL have port inst_q  output  32  latched instruction, feeds decoder.
REQ-009 SHALL have port opcode  input  7  decoder opcode of inst_q.
REQ-010 SHALL have port rd  input  5  decoder destination register of inst_q.
REQ-011 SHALL have port lsu_req_valid  output  1  data-memory request.
REQ-012 SHALL have port lsu_req_ready  input  1  LSU accepts request.
REQ-013 SHALL have port lsu_store  output  1  1 = store, 0 = load; valid with lsu_req_valid.
REQ-014 SHALL have port lsu_rsp_valid  input  1  LSU completion.
REQ-015 SHALL have port rf_we  output  1  register-file write enable.
REQ-016 SHALL have port pc_we  output  1  PC update enable.
REQ-017 SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-018 SHALL have port instret  output  XLEN  retired-instruction count.
REQ-019 SHALL have port trap  output  1  sticky fault flag.
REQ-020 SHALL have port trap_cause  output  2  0 none, 1 illegal opcode, 2 LSU timeout.

Function
REQ-021 SHALL implement FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP; all outputs Moore except rf_we/pc_we/retire decoded from state WB.
REQ-022 FETCH: ifu_req_valid=1; on ifu_rsp_valid latch inst_in into inst_q, go DECODE; else stay.
REQ-023 DECODE (1 cycle): opcode in {LOAD, MISC_MEM, OP_IMM, AUIPC, OP_IMM_32, STORE, OP, LUI, OP_32, BRANCH, JALR, JAL, SYSTEM} -> EXEC; any other -> TRAP, trap_cause=1.
REQ-024 EXEC (1 cycle): LOAD or STORE -> MEM; else -> WB.
REQ-025 MEM: lsu_req_valid=1 until the cycle lsu_req_ready=1 (inclusive), then low; lsu_store=(opcode==STORE).
REQ-026 MEM: lsu_rsp_valid counts only in or after the accept cycle; earlier pulses ignored.
REQ-027 MEM: accept and rsp in same cycle -> WB next cycle.
REQ-028 MEM: 8-bit counter clears on MEM entry, increments each MEM cycle; reaching MEM_TIMEOUT without rsp -> TRAP, trap_cause=2.
REQ-029 WB (1 cycle): pc_we=1, retire=1, instret+=1 (wraps modulo 2^XLEN), -> FETCH.
REQ-030 WB: rf_we=1 only if opcode not in {STORE, BRANCH, MISC_MEM, SYSTEM} and rd!=0.
REQ-031 TRAP: terminal until reset; trap=1, trap_cause held, all request/enable outputs 0.
REQ-032 ifu_rsp_valid outside FETCH SHALL be ignored; inst_q changes only in FETCH.
REQ-033 Latency: non-memory instruction = fetch response + 3 cycles to retire pulse.

Reset
REQ-034 rst low SHALL asynchronously force state FETCH, inst_q=0, instret=0, counter=0, trap=0, trap_cause=0.
REQ-035 rst assertion mid-MEM or mid-FETCH SHALL abandon the transaction; lsu_req_valid/ifu_req_valid drop during reset and ifu_req_valid rises in the first cycle after release.

Structure
REQ-036 Opcode constants, FSM state encoding and trap cause codes SHALL live in shared package rv_ctrl_pkg, shared with the decoder.
REQ-037 Opcode legality/class lookup SHALL be one sub-module, opcode_class (outputs legal, is_mem, is_store, writes_rd).

Verification
REQ-038 ADDI x1 (0x00100093), rsp in first FETCH cycle -> retire 3 cycles later, rf_we=1, instret 0->1.
REQ-039 LW, lsu_req_ready after 2 cycles, rsp 3 cycles later -> lsu_store=0, single accept, retire after rsp, rf_we=1.
REQ-040 SW with ready and rsp same cycle -> lsu_store=1, WB next cycle, rf_we=0.
REQ-041 Opcode 7'b1010111 -> trap=1, trap_cause=1, no retire, ifu_req_valid stays 0.
REQ-042 LOAD, no lsu_rsp_valid for MEM_TIMEOUT=16 cycles -> trap_cause=2; rst low mid-MEM -> all outputs 0, FETCH after release.
